cdr_frame_ctrl: RTL

Receive-side sequencer for the Zigbee CDR/decision path.
- Releases and configures the CDR decision stage (samples-per-bit, run/hold).
- Consumes its recovered bit stream and strobe, hunts for the preamble and SFD, and parses the PHR length.
- Emits payload bytes with frame delimiters, and restarts the CDR after errors or timeouts.

---
 rtl/cdr_frame_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cdr_frame_ctrl.sv
// Receive-side sequencer for the Zigbee CDR path: preamble/SFD hunt, PHR parse, payload bytes.
// Optional CRC_CHK_EN adds a CRC-16/ITU-T check over the payload, reported on o_crc_ok.
module cdr_frame_ctrl #(
  parameter int unsigned PREAMBLE_BITS = 32,
  parameter logic [7:0]  SFD_VAL       = 8'hA7,
  parameter int unsigned SFD_WIN       = 16,
  parameter int unsigned MAX_LEN       = 127,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [5:0] i_nb_p_cfg,
  input  logic       i_bit,
  input  logic       i_bit_vld,
  output logic       o_cdr_run,
  output logic [5:0] o_nb_p,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic       o_sof,
  output logic       o_eof,
  output logic [6:0] o_len,
  output logic       o_err_sfd,
  output logic       o_err_len,
  output logic       o_err_to,
  output logic       o_busy,
  output logic       o_crc_ok
);

  localparam int unsigned ZCNT_W = $clog2(PREAMBLE_BITS + 1);
  localparam int unsigned BCNT_W = ($clog2(SFD_WIN) > 3) ? $clog2(SFD_WIN) : 3;
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_SFD, S_PHR, S_PAYLOAD, S_DONE, S_RESYNC
  } state_t;

  state_t             r_state, w_next;
  logic [ZCNT_W-1:0]  r_zero_cnt, w_zero_inc;
  logic [BCNT_W-1:0]  r_bit_cnt;
  logic [WD_W-1:0]    r_wd;
  logic [7:0]         r_sr, w_sr_shift;
  logic [6:0]         r_byte_cnt, r_len;
  logic [7:0]         r_byte;
  logic [5:0]         r_nb_p;
  logic               r_cdr_run, r_busy, r_byte_vld, r_sof, r_eof;
  logic               r_err_sfd, r_err_len, r_err_to, r_crc_ok;
  logic               w_sof, w_err_sfd, w_err_len, w_err_to, w_byte_done;
  logic               w_wd_expire, w_data_st, w_crc_good;

`ifdef CRC_CHK_EN
  localparam logic [15:0] CRC_POLY = 16'h8408;
  logic [15:0] r_crc, w_crc_upd;

  // Reflected CRC-16/ITU-T, one bit per payload strobe
  always_comb begin
    w_crc_upd = {1'b0, r_crc[15:1]} ^ ((r_crc[0] ^ i_bit) ? CRC_POLY : 16'h0000);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc <= 16'h0000;
    end else if (r_state == S_PAYLOAD && i_bit_vld) begin
      r_crc <= w_crc_upd;
    end else if (r_state != S_PAYLOAD && w_next == S_PAYLOAD) begin
      r_crc <= 16'h0000;
    end
  end

  assign w_crc_good = (r_crc == 16'h0000);
`else
  assign w_crc_good = 1'b1;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and one-cycle event decode
  always_comb begin
    w_next      = r_state;
    w_sof       = 1'b0;
    w_err_sfd   = 1'b0;
    w_err_len   = 1'b0;
    w_err_to    = 1'b0;
    w_byte_done = 1'b0;
    w_sr_shift  = {i_bit, r_sr[7:1]};
    w_zero_inc  = (r_zero_cnt == ZCNT_W'(PREAMBLE_BITS)) ? r_zero_cnt : r_zero_cnt + ZCNT_W'(1);
    w_data_st   = (r_state inside {S_SFD, S_PHR, S_PAYLOAD});
    // A strobe arriving on the expiry clock wins over the watchdog
    w_wd_expire = w_data_st && !i_bit_vld && (r_wd == WD_W'(TIMEOUT - 1));
    case (r_state)
      S_IDLE: if (i_en) w_next = S_HUNT;
      S_HUNT: begin
        if (!i_en) w_next = S_IDLE;
        else if (i_bit_vld && !i_bit && w_zero_inc == ZCNT_W'(PREAMBLE_BITS)) w_next = S_SFD;
      end
      S_SFD: begin
        if (i_bit_vld) begin
          if (w_sr_shift == SFD_VAL) begin
            w_sof  = 1'b1;
            w_next = S_PHR;
          end else if (r_bit_cnt == BCNT_W'(SFD_WIN - 1)) begin
            w_err_sfd = 1'b1;
            w_next    = S_RESYNC;
          end
        end
      end
      S_PHR: begin
        if (i_bit_vld && r_bit_cnt == BCNT_W'(7)) begin
          if (w_sr_shift[6:0] == 7'd0 || 32'(w_sr_shift[6:0]) > MAX_LEN) begin
            w_err_len = 1'b1;
            w_next    = S_RESYNC;
          end else begin
            w_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (i_bit_vld && r_bit_cnt == BCNT_W'(7)) begin
          w_byte_done = 1'b1;
          if (r_byte_cnt == 7'd1) w_next = S_DONE;
        end
      end
      S_DONE, S_RESYNC: w_next = i_en ? S_HUNT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_wd_expire) begin
      w_err_to = 1'b1;
      w_next   = S_RESYNC;
    end
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_zero_cnt <= '0;
      r_bit_cnt  <= '0;
      r_wd       <= '0;
      r_sr       <= 8'h00;
      r_byte_cnt <= 7'd0;
      r_len      <= 7'd0;
      r_byte     <= 8'h00;
      r_nb_p     <= 6'd2;
      r_cdr_run  <= 1'b0;
      r_busy     <= 1'b0;
      r_byte_vld <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_err_sfd  <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_to   <= 1'b0;
      r_crc_ok   <= 1'b0;
    end else begin
      r_cdr_run  <= (w_next != S_IDLE) && (w_next != S_RESYNC);
      r_busy     <= (w_next != S_IDLE);
      r_byte_vld <= w_byte_done;
      r_sof      <= w_sof;
      r_err_sfd  <= w_err_sfd;
      r_err_len  <= w_err_len;
      r_err_to   <= w_err_to;
      r_eof      <= (r_state == S_DONE);
      r_crc_ok   <= (r_state == S_DONE) && w_crc_good;
      if (r_state == S_IDLE && w_next == S_HUNT)
        r_nb_p <= (i_nb_p_cfg < 6'd2) ? 6'd2 : i_nb_p_cfg;
      if (w_byte_done) r_byte <= w_sr_shift;
      if (r_state == S_PHR && i_bit_vld && r_bit_cnt == BCNT_W'(7)) r_len <= w_sr_shift[6:0];
      if (r_state != S_PAYLOAD && w_next == S_PAYLOAD) r_byte_cnt <= w_sr_shift[6:0];
      else if (w_byte_done)                            r_byte_cnt <= r_byte_cnt - 7'd1;
      // Every state entry starts its bit collection from scratch
      if (w_next != r_state) begin
        r_zero_cnt <= '0;
        r_sr       <= 8'h00;
        r_bit_cnt  <= '0;
      end else if (i_bit_vld) begin
        case (r_state)
          S_HUNT: r_zero_cnt <= i_bit ? '0 : w_zero_inc;
          S_SFD: begin
            r_sr      <= w_sr_shift;
            r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
          end
          S_PHR, S_PAYLOAD: begin
            r_sr      <= w_sr_shift;
            r_bit_cnt <= (r_bit_cnt == BCNT_W'(7)) ? '0 : r_bit_cnt + BCNT_W'(1);
          end
          default: ;
        endcase
      end
      if (w_next != r_state || i_bit_vld || !w_data_st) r_wd <= '0;
      else                                               r_wd <= r_wd + WD_W'(1);
    end
  end

  assign o_cdr_run  = r_cdr_run;
  assign o_nb_p     = r_nb_p;
  assign o_byte     = r_byte;
  assign o_byte_vld = r_byte_vld;
  assign o_sof      = r_sof;
  assign o_eof      = r_eof;
  assign o_len      = r_len;
  assign o_err_sfd  = r_err_sfd;
  assign o_err_len  = r_err_len;
  assign o_err_to   = r_err_to;
  assign o_busy     = r_busy;
  assign o_crc_ok   = r_crc_ok;

endmodule
